// File: rtl/ibex_branch_predict_ctrl.sv
// Branch prediction tracker: in-order FIFO of IF-stage predictions checked against EX resolution.
// Optional perf counters enabled by defining IBEX_BP_PERF_CNT_EN.
module ibex_branch_predict_ctrl #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       fetch_valid_i,
   input  logic                       fetch_ready_i,
   input  logic                       fetch_is_cf_i,
   input  logic                       fetch_compressed_i,
   input  logic [31:0]                fetch_pc_i,
   input  logic                       predict_taken_i,
   input  logic [31:0]                predict_pc_i,
   input  logic                       resolve_valid_i,
   input  logic                       resolve_taken_i,
   input  logic [31:0]                resolve_target_i,
   input  logic                       flush_i,
   output logic                       fetch_stall_o,
   output logic                       mispredict_o,
   output logic [31:0]                redirect_pc_o,
   output logic [$clog2(DEPTH):0]     outstanding_o,
   output logic [31:0]                perf_resolved_o,
   output logic [31:0]                perf_mispredict_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef enum logic {
      IDLE,
      FLUSH
   } state_t;

   state_t state, state_d;

   logic          q_taken  [DEPTH];
   logic [31:0]   q_target [DEPTH];
   logic [31:0]   q_fall   [DEPTH];

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   redirect_q;

   logic          full, empty, idle;
   logic          push, pop, mismatch;
   logic          h_taken;
   logic [31:0]   h_target, h_fall;
   logic [31:0]   fallthrough, correct_pc;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign idle  = (state == IDLE);

   assign h_taken  = q_taken[rd_ptr];
   assign h_target = q_target[rd_ptr];
   assign h_fall   = q_fall[rd_ptr];

   assign fallthrough = fetch_pc_i
                      + (fetch_compressed_i ? 32'd2 : 32'd4);

   assign pop = resolve_valid_i & ~empty & ~flush_i & idle;

   assign mismatch = pop &
      ((resolve_taken_i != h_taken) |
       (resolve_taken_i & (resolve_target_i != h_target)));

   // Entries fetched alongside a mispredict are already wrong-path.
   assign push = fetch_valid_i & fetch_ready_i & fetch_is_cf_i
               & ~full & idle & ~flush_i & ~mismatch;

   assign correct_pc = resolve_taken_i ? resolve_target_i : h_fall;

   assign fetch_stall_o = full & fetch_valid_i & fetch_is_cf_i;
   assign mispredict_o  = (state == FLUSH);
   assign redirect_pc_o = redirect_q;
   assign outstanding_o = count;

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (mismatch) state_d = FLUSH;
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i || mismatch) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= PW'(wr_ptr + 1'b1);
         if (pop)  rd_ptr <= PW'(rd_ptr + 1'b1);
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_taken[i]  <= 1'b0;
            q_target[i] <= '0;
            q_fall[i]   <= '0;
         end
      end else if (push) begin
         q_taken[wr_ptr]  <= predict_taken_i;
         q_target[wr_ptr] <= predict_pc_i;
         q_fall[wr_ptr]   <= fallthrough;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         redirect_q <= '0;
      end else if (mismatch) begin
         redirect_q <= correct_pc;
      end
   end

`ifdef IBEX_BP_PERF_CNT_EN
   logic [31:0] perf_res_q, perf_mis_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_res_q <= '0;
         perf_mis_q <= '0;
      end else begin
         if (pop && perf_res_q != 32'hFFFF_FFFF)
            perf_res_q <= perf_res_q + 32'd1;
         if (mismatch && perf_mis_q != 32'hFFFF_FFFF)
            perf_mis_q <= perf_mis_q + 32'd1;
      end
   end

   assign perf_resolved_o   = perf_res_q;
   assign perf_mispredict_o = perf_mis_q;
`else
   assign perf_resolved_o   = '0;
   assign perf_mispredict_o = '0;
`endif

`ifndef SYNTHESIS
   resolve_nonempty: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (resolve_valid_i && idle && !flush_i) |-> !empty
   );
`endif

endmodule

// File: tb/tb_ibex_branch_predict_ctrl.sv
// Directed bench for ibex_branch_predict_ctrl with a redirect scoreboard.
module tb_ibex_branch_predict_ctrl;

   localparam int DEPTH = 2;

`ifdef IBEX_BP_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        fetch_valid_i, fetch_ready_i, fetch_is_cf_i;
   logic        fetch_compressed_i;
   logic [31:0] fetch_pc_i;
   logic        predict_taken_i;
   logic [31:0] predict_pc_i;
   logic        resolve_valid_i, resolve_taken_i;
   logic [31:0] resolve_target_i;
   logic        flush_i;
   logic        fetch_stall_o, mispredict_o;
   logic [31:0] redirect_pc_o;
   logic [$clog2(DEPTH):0] outstanding_o;
   logic [31:0] perf_resolved_o, perf_mispredict_o;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   logic prev_misp = 1'b0;

   always #5 clk_i = ~clk_i;

   ibex_branch_predict_ctrl #(.DEPTH(DEPTH)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .fetch_valid_i     (fetch_valid_i),
      .fetch_ready_i     (fetch_ready_i),
      .fetch_is_cf_i     (fetch_is_cf_i),
      .fetch_compressed_i(fetch_compressed_i),
      .fetch_pc_i        (fetch_pc_i),
      .predict_taken_i   (predict_taken_i),
      .predict_pc_i      (predict_pc_i),
      .resolve_valid_i   (resolve_valid_i),
      .resolve_taken_i   (resolve_taken_i),
      .resolve_target_i  (resolve_target_i),
      .flush_i           (flush_i),
      .fetch_stall_o     (fetch_stall_o),
      .mispredict_o      (mispredict_o),
      .redirect_pc_o     (redirect_pc_o),
      .outstanding_o     (outstanding_o),
      .perf_resolved_o   (perf_resolved_o),
      .perf_mispredict_o (perf_mispredict_o)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every redirect pulse must match the oldest expected target.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         prev_misp = 1'b0;
      end else begin
         if (mispredict_o) begin
            checks++;
            if (prev_misp) begin
               errors++;
               $display("FAIL back_to_back_pulse: got 1 expected 0");
            end
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_mispredict: got pc %h expected none",
                        redirect_pc_o);
            end else begin
               chk("redirect_pc", redirect_pc_o, exp_q.pop_front());
            end
         end
         prev_misp = mispredict_o;
      end
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr();
      fetch_valid_i      = 1'b0;
      fetch_ready_i      = 1'b0;
      fetch_is_cf_i      = 1'b0;
      fetch_compressed_i = 1'b0;
      fetch_pc_i         = '0;
      predict_taken_i    = 1'b0;
      predict_pc_i       = '0;
      resolve_valid_i    = 1'b0;
      resolve_taken_i    = 1'b0;
      resolve_target_i   = '0;
      flush_i            = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic comp,
                        input logic tk, input logic [31:0] tgt);
      fetch_valid_i      = 1'b1;
      fetch_ready_i      = 1'b1;
      fetch_is_cf_i      = 1'b1;
      fetch_compressed_i = comp;
      fetch_pc_i         = pc;
      predict_taken_i    = tk;
      predict_pc_i       = tgt;
   endtask

   task automatic resolve(input logic tk, input logic [31:0] tgt);
      resolve_valid_i  = 1'b1;
      resolve_taken_i  = tk;
      resolve_target_i = tgt;
   endtask

   initial begin
      clr();
      rst_ni = 1'b0;
      repeat (2) cyc();
      chk("rst_outstanding", 32'(outstanding_o), 0);
      chk("rst_mispredict", 32'(mispredict_o), 0);
      chk("rst_redirect", redirect_pc_o, 0);
      chk("rst_stall", 32'(fetch_stall_o), 0);
      rst_ni = 1'b1;
      cyc();

      // Backward branch predicted correctly
      fetch(32'h100, 1'b0, 1'b1, 32'hF0);
      cyc();
      chk("t1_out_push", 32'(outstanding_o), 1);
      clr();
      resolve(1'b1, 32'hF0);
      cyc();
      chk("t1_out_pop", 32'(outstanding_o), 0);
      chk("t1_perf_res", perf_resolved_o, PERF ? 32'd1 : 32'd0);
      chk("t1_perf_mis", perf_mispredict_o, 0);
      clr();

      // Forward branch, predicted not taken, actually taken
      fetch(32'h200, 1'b0, 1'b0, 32'h999);
      cyc();
      clr();
      resolve(1'b1, 32'h240);
      exp_q.push_back(32'h240);
      cyc();
      chk("t2_out", 32'(outstanding_o), 0);
      clr();
      cyc();
      cyc();
      chk("t2_hold_redirect", redirect_pc_o, 32'h240);
      chk("t2_pulse_done", 32'(mispredict_o), 0);

      // Compressed branch, predicted taken, not taken; wrong-path pushes dropped
      fetch(32'h300, 1'b1, 1'b1, 32'h280);
      cyc();
      fetch(32'h304, 1'b0, 1'b0, 32'h0);
      resolve(1'b0, 32'h0);
      exp_q.push_back(32'h302);
      cyc();
      chk("t3_same_cycle_push", 32'(outstanding_o), 0);
      clr();
      fetch(32'h308, 1'b0, 1'b0, 32'h0);
      cyc();
      chk("t3_flush_state_push", 32'(outstanding_o), 0);
      clr();

      // DEPTH=2 back-pressure and simultaneous push/pop
      fetch(32'h400, 1'b0, 1'b0, 32'h0);
      cyc();
      fetch(32'h404, 1'b0, 1'b0, 32'h0);
      cyc();
      chk("t4_full", 32'(outstanding_o), 2);
      fetch(32'h408, 1'b0, 1'b0, 32'h0);
      #1;
      chk("t4_stall", 32'(fetch_stall_o), 1);
      cyc();
      chk("t4_no_push", 32'(outstanding_o), 2);
      resolve(1'b0, 32'h0);
      #1;
      chk("t4_stall_no_bypass", 32'(fetch_stall_o), 1);
      cyc();
      chk("t4_pop_only", 32'(outstanding_o), 1);
      #1;
      chk("t4_stall_clear", 32'(fetch_stall_o), 0);
      cyc();
      chk("t4_push_pop", 32'(outstanding_o), 1);
      clr();
      fetch(32'h40C, 1'b0, 1'b1, 32'h500);
      cyc();
      chk("t4_refill", 32'(outstanding_o), 2);
      clr();
      resolve(1'b0, 32'h0);
      cyc();
      chk("t4_drain", 32'(outstanding_o), 1);
      exp_q.push_back(32'h410);
      cyc();
      chk("t4_mis_clear", 32'(outstanding_o), 0);
      chk("t4_perf_res", perf_resolved_o, PERF ? 32'd7 : 32'd0);
      chk("t4_perf_mis", perf_mispredict_o, PERF ? 32'd3 : 32'd0);
      clr();
      cyc();

      // Controller flush overrides a mismatching resolve
      fetch(32'h600, 1'b0, 1'b0, 32'h0);
      cyc();
      chk("t5_push", 32'(outstanding_o), 1);
      clr();
      resolve(1'b1, 32'h700);
      flush_i = 1'b1;
      cyc();
      chk("t5_out", 32'(outstanding_o), 0);
      chk("t5_no_pulse", 32'(mispredict_o), 0);
      clr();
      cyc();
      chk("t5_no_pulse_late", 32'(mispredict_o), 0);
      fetch(32'h610, 1'b0, 1'b0, 32'h0);
      flush_i = 1'b1;
      cyc();
      chk("t5_flush_blocks_push", 32'(outstanding_o), 0);
      clr();
      cyc();

      // Fallthrough wrap, then reset in the middle of the redirect pulse
      fetch(32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFC);
      cyc();
      clr();
      resolve(1'b0, 32'h0);
      cyc();
      clr();
      chk("t6_pulse", 32'(mispredict_o), 1);
      chk("t6_wrap_redirect", redirect_pc_o, 32'h0);
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_pulse_drop", 32'(mispredict_o), 0);
      chk("t6_rst_out", 32'(outstanding_o), 0);
      cyc();
      rst_ni = 1'b1;
      cyc();
      chk("t6_idle_after_rst", 32'(mispredict_o), 0);

      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
